// File: rtl/csa_pkg.sv
// Shared sizing helpers for the carry-save resolve pipeline: stage count
// derivation, per-stage chunk width and stage payload width.
package csa_pkg;

    localparam int S_WIDTH_DEF = 18;
    localparam int C_WIDTH_DEF = 17;
    localparam int CHUNK_DEF   = 6;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int num_stages(input int s_width, input int chunk);
        return ceil_div(s_width, chunk);
    endfunction

    // The top slice is narrower when the sum width is not a multiple of the chunk.
    function automatic int chunk_width(input int s_width, input int lo, input int chunk);
        return ((s_width - lo) < chunk) ? (s_width - lo) : chunk;
    endfunction

    // Registered payload per stage: sum + carry delay regs, result bits, carry bit.
    function automatic int payload_width(input int s_width);
        return 3 * s_width + 1;
    endfunction

    localparam int NSTAGES_DEF = num_stages(S_WIDTH_DEF, CHUNK_DEF);
    localparam int PAYLOAD_W_DEF = payload_width(S_WIDTH_DEF);

endpackage

// File: rtl/csa_resolve_stage.sv
// One pipeline slice: adds one chunk of the redundant pair plus the incoming
// carry and registers the partial result alongside the still-redundant bits.
module csa_resolve_stage
    import csa_pkg::*;
#(
    parameter int S_WIDTH = S_WIDTH_DEF,
    parameter int CHUNK   = CHUNK_DEF,
    parameter int LO      = 0,
    parameter bit LAST    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic [S_WIDTH-1:0] in_sum,
    input  logic [S_WIDTH-1:0] in_carry,
    input  logic [S_WIDTH-1:0] in_res,
    input  logic               in_cy,
`ifdef CSA_RESOLVE_FLAGS_EN
    input  logic               in_zero,
    output logic               out_zero,
`endif
    output logic               out_valid,
    output logic [S_WIDTH-1:0] out_sum,
    output logic [S_WIDTH-1:0] out_carry,
    output logic [S_WIDTH-1:0] out_res,
    output logic               out_cy
);

    localparam int W = chunk_width(S_WIDTH, LO, CHUNK);

    logic [W:0]         add;
    logic [S_WIDTH-1:0] res_next;

    assign add = {1'b0, in_sum[LO +: W]} + {1'b0, in_carry[LO +: W]} + {{W{1'b0}}, in_cy};

    always_comb begin
        res_next = in_res;
        res_next[LO +: W] = add[W-1:0];
    end

`ifdef CSA_RESOLVE_FLAGS_EN
    // The final slice also folds in the carry-out, since it becomes the result MSB.
    logic zero_next;
    always_comb begin
        zero_next = in_zero && (add[W-1:0] == '0) && !(LAST && add[W]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_zero <= 1'b0;
        end else if (en) begin
            out_zero <= zero_next;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_carry <= '0;
            out_res   <= '0;
            out_cy    <= 1'b0;
        end else if (en) begin
            out_valid <= in_valid;
            out_sum   <= in_sum;
            out_carry <= in_carry;
            out_res   <= res_next;
            out_cy    <= add[W];
        end
    end

endmodule

// File: rtl/csa_resolve_pipe.sv
// Resolves a weight-aligned (sum, carry) pair into binary through a chunked,
// pipelined carry-propagate adder. Optional zero/overflow flags: CSA_RESOLVE_FLAGS_EN.
module csa_resolve_pipe
    import csa_pkg::*;
#(
    parameter int S_WIDTH = S_WIDTH_DEF,
    parameter int C_WIDTH = C_WIDTH_DEF,
    parameter int CHUNK   = CHUNK_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [S_WIDTH-1:0] in_sum,
    input  logic [C_WIDTH-1:0] in_carry,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef CSA_RESOLVE_FLAGS_EN
    output logic               out_zero,
    output logic               out_ovf,
`endif
    output logic [S_WIDTH:0]   out_data
);

    localparam int NSTAGES = num_stages(S_WIDTH, CHUNK);

    if (C_WIDTH > S_WIDTH) begin : g_width_check
        $error("csa_resolve_pipe: C_WIDTH (%0d) exceeds S_WIDTH (%0d)", C_WIDTH, S_WIDTH);
    end

    logic               adv;
    logic [S_WIDTH-1:0] carry_ext;

    logic               v_c     [0:NSTAGES];
    logic [S_WIDTH-1:0] sum_c   [0:NSTAGES];
    logic [S_WIDTH-1:0] carry_c [0:NSTAGES];
    logic [S_WIDTH-1:0] res_c   [0:NSTAGES];
    logic               cy_c    [0:NSTAGES];

    // The whole pipe moves as one; any stall freezes every stage.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        carry_ext = '0;
        carry_ext[C_WIDTH-1:0] = in_carry;
    end

    assign v_c[0]     = in_valid;
    assign sum_c[0]   = in_sum;
    assign carry_c[0] = carry_ext;
    assign res_c[0]   = '0;
    assign cy_c[0]    = 1'b0;

`ifdef CSA_RESOLVE_FLAGS_EN
    logic zero_c [0:NSTAGES];
    assign zero_c[0] = 1'b1;
`endif

    for (genvar g = 0; g < NSTAGES; g++) begin : g_stage
        csa_resolve_stage #(
            .S_WIDTH (S_WIDTH),
            .CHUNK   (CHUNK),
            .LO      (g * CHUNK),
            .LAST    (g == NSTAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (adv),
            .in_valid  (v_c[g]),
            .in_sum    (sum_c[g]),
            .in_carry  (carry_c[g]),
            .in_res    (res_c[g]),
            .in_cy     (cy_c[g]),
`ifdef CSA_RESOLVE_FLAGS_EN
            .in_zero   (zero_c[g]),
            .out_zero  (zero_c[g+1]),
`endif
            .out_valid (v_c[g+1]),
            .out_sum   (sum_c[g+1]),
            .out_carry (carry_c[g+1]),
            .out_res   (res_c[g+1]),
            .out_cy    (cy_c[g+1])
        );
    end

    assign out_valid = v_c[NSTAGES];
    assign out_data  = {cy_c[NSTAGES], res_c[NSTAGES]};

`ifdef CSA_RESOLVE_FLAGS_EN
    assign out_zero = zero_c[NSTAGES];
    assign out_ovf  = cy_c[NSTAGES];
`endif

endmodule
